// File: rtl/ad_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad_sched_pkg
// Description : Shared types and helpers for the AD7606 sample scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ad_sched_pkg;

   localparam int CH_NUM_DEF = 8;
   localparam int DW_DEF     = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_COLLECT = 2'd2,
      ST_PUBLISH = 2'd3
   } state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n = n + {31'd0, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ad_mask_slot_sel.sv
`default_nettype none
// ============================================================================
// Module      : ad_mask_slot_sel
// Description : Maps (mask, index) to the position of the index-th set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_mask_slot_sel #(
   parameter int CH_NUM = 8,
   parameter int SW     = 3,
   parameter int IW     = 4
) (
   input  logic [CH_NUM-1:0] i_mask,
   input  logic [IW-1:0]     i_index,
   output logic [SW-1:0]     o_slot,
   output logic              o_hit
);

   logic [IW-1:0] w_cnt;

   always_comb begin
      o_slot = '0;
      o_hit  = 1'b0;
      w_cnt  = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         if (i_mask[k]) begin
            if (!o_hit && (w_cnt == i_index)) begin
               o_slot = SW'(k);
               o_hit  = 1'b1;
            end
            w_cnt = w_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ad_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ad_sample_scheduler
// Description : Periodic AD7606 conversion trigger, frame assembly and
//               valid/ready hand-off to the DSP consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_sample_scheduler
   import ad_sched_pkg::*;
#(
   parameter int CH_NUM     = CH_NUM_DEF,
   parameter int DW         = DW_DEF,
   parameter int PERIOD_W   = 16,
   parameter int MIN_PERIOD = 64,
   parameter int TIMEOUT    = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [PERIOD_W-1:0]  period,
   input  logic [CH_NUM-1:0]    ch_mask,
   output logic                 start_o,
   input  logic                 smp_valid,
   input  logic [DW-1:0]        smp_data,
   output logic                 frame_valid,
   input  logic                 frame_ready,
   output logic [CH_NUM*DW-1:0] frame_data,
   output logic [CH_NUM-1:0]    frame_mask,
   output logic [7:0]           frame_seq,
   output logic [7:0]           missed_cnt,
   output logic [7:0]           overrun_cnt,
   output logic                 err_timeout
);

   localparam int c_sw = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int c_iw = $clog2(CH_NUM + 1);
   localparam int c_tw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [PERIOD_W-1:0] c_min_period = PERIOD_W'(MIN_PERIOD);
   localparam logic [c_tw-1:0]     c_tmo_last   = c_tw'(TIMEOUT - 1);

   state_e               r_state, w_state_nx;
   logic [PERIOD_W-1:0]  r_pcnt, r_pe, w_pe;
   logic                 w_tick;
   logic [CH_NUM-1:0]    r_mask, r_fmask;
   logic [c_iw-1:0]      r_exp, r_idx;
   logic [c_tw-1:0]      r_tcnt;
   logic [CH_NUM*DW-1:0] r_buf, r_fdata;
   logic                 r_start, r_fvalid, r_err;
   logic [7:0]           r_seq, r_missed, r_overrun;
   logic [c_sw-1:0]      w_slot;
   logic                 w_hit;
   logic                 w_trigger, w_done, w_tmo, w_take, w_load, w_drop, w_miss;

   // The effective period is re-sampled at the first count of every period.
   always_comb begin
      w_pe = r_pe;
      if (r_pcnt == '0) begin
         w_pe = (period < c_min_period) ? c_min_period : period;
      end
   end

   assign w_tick = enable && (r_pcnt == w_pe - 1'b1);

   ad_mask_slot_sel #(
      .CH_NUM (CH_NUM),
      .SW     (c_sw),
      .IW     (c_iw)
   ) u_slot_sel (
      .i_mask  (r_mask),
      .i_index (r_idx),
      .o_slot  (w_slot),
      .o_hit   (w_hit)
   );

   always_comb begin
      w_state_nx = r_state;
      w_trigger  = 1'b0;
      w_done     = 1'b0;
      w_tmo      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable && (ch_mask != '0)) w_state_nx = ST_ARM;
         end
         ST_ARM: begin
            if (!enable || (ch_mask == '0)) begin
               w_state_nx = ST_IDLE;
            end else if (w_tick) begin
               w_trigger  = 1'b1;
               w_state_nx = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            // A final sample arriving on the timeout cycle still completes the frame.
            if (smp_valid && (r_idx == r_exp - 1'b1)) begin
               w_done     = 1'b1;
               w_state_nx = ST_PUBLISH;
            end else if (r_tcnt == c_tmo_last) begin
               w_tmo      = 1'b1;
               w_state_nx = ST_ARM;
            end
         end
         ST_PUBLISH: begin
            w_state_nx = enable ? ST_ARM : ST_IDLE;
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   assign w_take = (r_state == ST_COLLECT) && smp_valid && w_hit;
   assign w_load = (r_state == ST_PUBLISH) && (!r_fvalid || frame_ready);
   assign w_drop = (r_state == ST_PUBLISH) && r_fvalid && !frame_ready;
   assign w_miss = w_tick && ((r_state == ST_COLLECT) || (r_state == ST_PUBLISH));

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcnt    <= '0;
         r_pe      <= c_min_period;
         r_start   <= 1'b0;
         r_mask    <= '0;
         r_exp     <= '0;
         r_idx     <= '0;
         r_tcnt    <= '0;
         r_buf     <= '0;
         r_fvalid  <= 1'b0;
         r_fdata   <= '0;
         r_fmask   <= '0;
         r_seq     <= '0;
         r_missed  <= '0;
         r_overrun <= '0;
         r_err     <= 1'b0;
      end else begin
         r_pcnt  <= (!enable || w_tick) ? '0 : r_pcnt + 1'b1;
         r_pe    <= w_pe;
         r_start <= w_trigger;
         if (w_trigger) begin
            r_mask <= ch_mask;
            r_exp  <= c_iw'(popcount(32'(ch_mask)));
            r_idx  <= '0;
            r_tcnt <= '0;
            r_buf  <= '0;
         end else if (r_state == ST_COLLECT) begin
            r_tcnt <= r_tcnt + 1'b1;
            if (w_take) begin
               r_buf[int'(w_slot)*DW +: DW] <= smp_data;
               r_idx <= r_idx + 1'b1;
            end
         end
         // A load coinciding with an accept keeps valid high with the new frame.
         if (w_load) begin
            r_fvalid <= 1'b1;
            r_fdata  <= r_buf;
            r_fmask  <= r_mask;
            r_seq    <= r_seq + 8'd1;
         end else if (r_fvalid && frame_ready) begin
            r_fvalid <= 1'b0;
         end
         if (w_drop) r_overrun <= sat_inc8(r_overrun);
         if (w_miss) r_missed  <= sat_inc8(r_missed);
         if (w_tmo)  r_err     <= 1'b1;
      end
   end

   assign start_o     = r_start;
   assign frame_valid = r_fvalid;
   assign frame_data  = r_fdata;
   assign frame_mask  = r_fmask;
   assign frame_seq   = r_seq;
   assign missed_cnt  = r_missed;
   assign overrun_cnt = r_overrun;
   assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ad_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad_sample_scheduler
// Description : Self-checking bench for ad_sample_scheduler with a front-end model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_sample_scheduler;

   logic         clk = 1'b0;
   logic         rst, enable, smp_valid, frame_ready;
   logic [15:0]  period, smp_data;
   logic [7:0]   ch_mask;
   logic         start_o, frame_valid, err_timeout;
   logic [127:0] frame_data;
   logic [7:0]   frame_mask, frame_seq, missed_cnt, overrun_cnt;

   always #5 clk = ~clk;

   ad_sample_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .period      (period),
      .ch_mask     (ch_mask),
      .start_o     (start_o),
      .smp_valid   (smp_valid),
      .smp_data    (smp_data),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_data  (frame_data),
      .frame_mask  (frame_mask),
      .frame_seq   (frame_seq),
      .missed_cnt  (missed_cnt),
      .overrun_cnt (overrun_cnt),
      .err_timeout (err_timeout)
   );

   typedef struct {
      logic [15:0] period;
      logic [7:0]  mask;
      int          gap;
      logic [15:0] base;
      int          spacing;
   } vec_t;

   vec_t        tbl [0:4];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          fe_count = 0;
   int          fe_gap = 0;
   logic [15:0] fe_vals [0:7];
   logic [7:0]  exp_seq = 8'd0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Front-end model: after each start_o, returns fe_count strobes, each preceded by fe_gap idle cycles.
   initial begin
      smp_valid = 1'b0;
      smp_data  = '0;
      forever begin
         @(posedge clk); #1;
         if (start_o) begin
            for (int s = 0; s < fe_count; s++) begin
               repeat (fe_gap) begin @(posedge clk); #1; end
               smp_valid = 1'b1;
               smp_data  = fe_vals[s];
               @(posedge clk); #1;
               smp_valid = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_start(input int budget, output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (start_o) begin ok = 1'b1; t = cyc; end
         else step(1);
      end
   endtask

   task automatic wait_fv(input int budget, output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (frame_valid) begin ok = 1'b1; t = cyc; end
         else step(1);
      end
   endtask

   // Expected frame: i-th returned sample lands in the i-th set mask bit, unset slots read zero.
   function automatic logic [127:0] model_frame(input logic [7:0] m);
      logic [127:0] r;
      int j;
      r = '0;
      j = 0;
      for (int k = 0; k < 8; k++) begin
         if (m[k]) begin
            r[k*16 +: 16] = fe_vals[j];
            j++;
         end
      end
      return r;
   endfunction

   task automatic set_vals(input logic [15:0] base);
      for (int k = 0; k < 8; k++) fe_vals[k] = base + 16'(k);
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] m, input int budget, input int hold);
      bit ok;
      int t;
      wait_fv(budget, t, ok);
      chk({tag, " valid"}, ok, 1'b1);
      if (ok) begin
         exp_seq = exp_seq + 8'd1;
         chk({tag, " data"}, frame_data, model_frame(m));
         chk({tag, " mask"}, frame_mask, m);
         chk({tag, " seq"}, frame_seq, exp_seq);
         step(hold);
         chk({tag, " held"}, {frame_valid, frame_seq}, {1'b1, exp_seq});
         frame_ready = 1'b1;
         step(1);
         frame_ready = 1'b0;
         chk({tag, " cleared"}, frame_valid, 1'b0);
      end
   endtask

   initial begin
      int   t0, t1, tv, te;
      bit   ok, seen, stable;
      logic [127:0] held;
      logic [7:0]   m;

      tbl[0] = '{16'd100, 8'hFF, 0, 16'h1000, 100};
      tbl[1] = '{16'd100, 8'hA4, 1, 16'hA000, 100};
      tbl[2] = '{16'd10,  8'hFF, 0, 16'h1100, 64};
      tbl[3] = '{16'd64,  8'h01, 2, 16'h1200, 64};
      tbl[4] = '{16'd200, 8'h80, 0, 16'h1300, 200};

      rst = 1'b1; enable = 1'b0; period = 16'd100; ch_mask = '0; frame_ready = 1'b0;
      step(3);
      chk("reset ctrl", {start_o, frame_valid, err_timeout, frame_mask, frame_seq, missed_cnt, overrun_cnt}, '0);
      chk("reset data", frame_data, '0);
      rst = 1'b0;
      step(2);

      for (int i = 0; i < 5; i++) begin
         enable = 1'b0; step(2);
         period = tbl[i].period; ch_mask = tbl[i].mask; fe_gap = tbl[i].gap;
         fe_count = $countones(tbl[i].mask);
         set_vals(tbl[i].base);
         enable = 1'b1;
         wait_start(1000, t0, ok);
         chk($sformatf("tbl%0d start", i), ok, 1'b1);
         step(1);
         chk($sformatf("tbl%0d start pulse", i), start_o, 1'b0);
         wait_fv(300, tv, ok);
         chk($sformatf("tbl%0d latency", i), tv - t0, (tbl[i].gap + 1) * fe_count + 1);
         expect_frame($sformatf("tbl%0d f1", i), tbl[i].mask, 300, 0);
         wait_start(400, t1, ok);
         chk($sformatf("tbl%0d spacing", i), t1 - t0, tbl[i].spacing);
         expect_frame($sformatf("tbl%0d f2", i), tbl[i].mask, 300, 1);
      end

      enable = 1'b0; step(2);
      ch_mask = '0; period = 16'd64; enable = 1'b1; seen = 1'b0;
      repeat (200) begin step(1); if (start_o) seen = 1'b1; end
      chk("mask0 no start", seen, 1'b0);

      // Consumer stalls: first frame held, later frames dropped, then accept coinciding with a load.
      enable = 1'b0; step(2);
      period = 16'd64; ch_mask = 8'hFF; fe_gap = 0; fe_count = 8; set_vals(16'h3000);
      enable = 1'b1;
      wait_fv(300, tv, ok);
      chk("ovr first valid", ok, 1'b1);
      exp_seq = exp_seq + 8'd1;
      held = model_frame(8'hFF);
      chk("ovr first data", frame_data, held);
      set_vals(16'h4000);
      stable = 1'b1;
      repeat (148) begin
         step(1);
         if (!frame_valid || frame_data !== held || frame_seq !== exp_seq) stable = 1'b0;
      end
      chk("ovr hold stable", stable, 1'b1);
      chk("ovr count", overrun_cnt, 8'd2);
      set_vals(16'h5000);
      wait_start(100, t0, ok);
      chk("same-cycle start", ok, 1'b1);
      step(8);
      frame_ready = 1'b1; step(1); frame_ready = 1'b0;
      exp_seq = exp_seq + 8'd1;
      chk("same-cycle valid", frame_valid, 1'b1);
      chk("same-cycle data", frame_data, model_frame(8'hFF));
      chk("same-cycle seq", frame_seq, exp_seq);
      chk("same-cycle ovr", overrun_cnt, 8'd2);
      frame_ready = 1'b1; step(1); frame_ready = 1'b0;
      chk("same-cycle accept", frame_valid, 1'b0);

      enable = 1'b0; step(2);
      period = 16'd1100; fe_count = 7; set_vals(16'h2000);
      enable = 1'b1;
      wait_start(1200, t0, ok);
      chk("tmo start", {ok, err_timeout}, 2'b10);
      seen = 1'b0; te = -1;
      for (int i = 0; i < 1100 && te < 0; i++) begin
         step(1);
         if (frame_valid) seen = 1'b1;
         if (err_timeout) te = cyc;
      end
      chk("tmo latency", te - t0, 1024);
      chk("tmo no frame", seen, 1'b0);
      fe_count = 8;
      expect_frame("tmo recover", 8'hFF, 1200, 0);
      chk("tmo sticky", err_timeout, 1'b1);

      enable = 1'b0; step(2);
      chk("missed before", missed_cnt, 8'd0);
      period = 16'd100; fe_gap = 18; fe_count = 8; set_vals(16'h6000);
      enable = 1'b1;
      expect_frame("slow f1", 8'hFF, 400, 0);
      expect_frame("slow f2", 8'hFF, 400, 0);
      chk("missed count", missed_cnt, 8'd2);
      wait_start(200, t0, ok);
      chk("rst start", ok, 1'b1);
      step(5);
      rst = 1'b1; step(1);
      chk("rst ctrl", {start_o, frame_valid, err_timeout, frame_mask, frame_seq, missed_cnt, overrun_cnt}, '0);
      chk("rst data", frame_data, '0);
      rst = 1'b0; enable = 1'b0; exp_seq = 8'd0;
      step(200);

      for (int i = 0; i < 20; i++) begin
         enable = 1'b0; step(2);
         m = 8'($urandom_range(1, 255));
         ch_mask = m;
         period = 16'($urandom_range(0, 100));
         fe_gap = $urandom_range(0, 3);
         fe_count = $countones(m);
         for (int k = 0; k < 8; k++) fe_vals[k] = 16'($urandom);
         enable = 1'b1;
         expect_frame($sformatf("rnd%0d", i), m, 300, $urandom_range(0, 3));
      end
      enable = 1'b0; step(2);
      chk("rnd counters", {missed_cnt, overrun_cnt, err_timeout}, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
